fsm_state_monitor: RTL and testbench



---
 rtl/fsm_mon_pkg.sv | 19 +
 rtl/trans_fifo.sv | 46 ++++
 rtl/fsm_state_monitor.sv | 99 +++++++++
 tb/tb_fsm_state_monitor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fsm_mon_pkg.sv
// Shared types for the activity-4 FSM state monitor: state encoding and the
// {from,to} transition record logged into the readout FIFO.
package fsm_mon_pkg;

  localparam int STATE_W    = 3;
  localparam int NUM_STATES = 5;

  typedef logic [STATE_W-1:0] state_t;

  typedef struct packed {
    state_t from;
    state_t to;
  } trans_t;

  function automatic logic is_illegal(input state_t s);
    return int'(s) >= NUM_STATES;
  endfunction

endpackage

// File: rtl/trans_fifo.sv
// Generic synchronous show-ahead FIFO: dout shows the head entry while !empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module trans_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fsm_state_monitor.sv
// Observer of the activity-4 FSM: logs {from,to} transitions into a FIFO, counts
// transitions and dwell time, and raises sticky illegal-encoding / prediction flags.
module fsm_state_monitor
  import fsm_mon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [STATE_W-1:0]   currentState,
  input  logic [STATE_W-1:0]   nextState,
  input  logic                 clr,
  input  logic                 rd_en,
  output logic [2*STATE_W-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic [CNT_W-1:0]     trans_count,
  output logic [CNT_W-1:0]     dwell,
  output logic                 illegal,
  output logic [STATE_W-1:0]   illegal_state,
  output logic                 pred_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t prev_q;
  state_t nxt_q;
  logic   primed;
  trans_t entry;
  logic   transition;
  logic   overflow_evt;
  logic   illegal_evt;
  logic   pred_evt;

  // Nothing is compared until one real sample of the monitored FSM exists.
  assign transition   = primed && (currentState != prev_q);
  assign overflow_evt = transition && full && !rd_en;
  assign illegal_evt  = primed && is_illegal(currentState) && !illegal;
  assign pred_evt     = primed && (currentState != nxt_q);
  assign entry        = '{from: prev_q, to: currentState};

  trans_fifo #(
    .WIDTH($bits(trans_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (transition),
    .pop  (rd_en),
    .din  (entry),
    .dout (rd_data),
    .empty(empty),
    .full (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= '0;
      nxt_q         <= '0;
      primed        <= 1'b0;
      trans_count   <= '0;
      dwell         <= '0;
      overflow      <= 1'b0;
      illegal       <= 1'b0;
      illegal_state <= '0;
      pred_err      <= 1'b0;
    end else begin
      prev_q <= currentState;
      nxt_q  <= nextState;
      primed <= 1'b1;
      // clr wins over any same-cycle event; the FIFO push is handled separately.
      if (clr) begin
        trans_count   <= '0;
        dwell         <= '0;
        overflow      <= 1'b0;
        illegal       <= 1'b0;
        illegal_state <= '0;
        pred_err      <= 1'b0;
      end else begin
        if (transition) begin
          if (trans_count != CNT_MAX) trans_count <= trans_count + CNT_ONE;
          dwell <= CNT_ONE;
        end else if (dwell != CNT_MAX) begin
          dwell <= dwell + CNT_ONE;
        end
        if (overflow_evt) overflow <= 1'b1;
        if (illegal_evt) begin
          illegal       <= 1'b1;
          illegal_state <= currentState;
        end
        if (pred_evt) pred_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed bench for fsm_state_monitor: hand-computed transitions, FIFO order,
// flag and counter values checked one cycle after each stimulus edge.
module tb_fsm_state_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] currentState;
  logic [2:0] nextState;
  logic       clr;
  logic       rd_en;
  logic [5:0] rd_data;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] trans_count;
  logic [7:0] dwell;
  logic       illegal;
  logic [2:0] illegal_state;
  logic       pred_err;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  fsm_state_monitor dut (
    .clk(clk), .reset(reset), .currentState(currentState), .nextState(nextState),
    .clr(clr), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .overflow(overflow), .trans_count(trans_count), .dwell(dwell),
    .illegal(illegal), .illegal_state(illegal_state), .pred_err(pred_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] cs, input logic [2:0] ns);
    currentState = cs;
    nextState    = ns;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 1'b0; rd_en = 1'b0; currentState = 3'd0; nextState = 3'd0;
    step(); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0d exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", full); end
    checks++; if (rd_data !== 6'd0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
    checks++; if (dwell !== 8'd0) begin errors++; $display("FAIL reset_dwell got %0d exp 0", dwell); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) drive(3'd0, 3'd0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL steady_empty got %0d exp 1", empty); end
    checks++; if (trans_count !== 8'd0) begin errors++; $display("FAIL steady_count got %0d exp 0", trans_count); end
    checks++; if (dwell !== 8'd10) begin errors++; $display("FAIL steady_dwell got %0d exp 10", dwell); end
    checks++; if ({overflow, illegal, pred_err} !== 3'b000) begin errors++; $display("FAIL steady_flags got %b exp 000", {overflow, illegal, pred_err}); end
  endtask

  task automatic test_sequence();
    logic [5:0] e;
    exp_q = '{6'd1, 6'd10, 6'd17};
    drive(3'd0, 3'd1);
    drive(3'd1, 3'd2);
    checks++; if (empty !== 1'b0 || rd_data !== 6'd1) begin errors++; $display("FAIL seq_first_push got empty=%0d data=%0d exp empty=0 data=1", empty, rd_data); end
    drive(3'd2, 3'd1);
    drive(3'd1, 3'd1);
    checks++; if (trans_count !== 8'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", trans_count); end
    checks++; if (pred_err !== 1'b0) begin errors++; $display("FAIL seq_pred_err got %0d exp 0", pred_err); end
    checks++; if (dwell !== 8'd1) begin errors++; $display("FAIL seq_dwell got %0d exp 1", dwell); end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin errors++; $display("FAIL seq_pop%0d got %0d exp %0d", k, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL seq_drained got %0d exp 1", empty); end
  endtask

  task automatic test_overflow();
    logic [5:0] e;
    clr = 1'b1; drive(3'd1, 3'd2); clr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      drive((i % 2 == 0) ? 3'd2 : 3'd1, (i == 8) ? 3'd2 : ((i % 2 == 0) ? 3'd1 : 3'd2));
      if (i < 8) exp_q.push_back((i % 2 == 0) ? 6'd10 : 6'd17);
      if (i == 7) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full8 got full=%0d ovf=%0d exp full=1 ovf=0", full, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d exp 1", overflow); end
    checks++; if (trans_count !== 8'd9) begin errors++; $display("FAIL ovf_count got %0d exp 9", trans_count); end
    // Clear overflow, then push while full with a simultaneous pop.
    clr = 1'b1; drive(3'd2, 3'd1); clr = 1'b0;
    checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL clr_keeps_fifo got ovf=%0d full=%0d exp ovf=0 full=1", overflow, full); end
    rd_en = 1'b1; drive(3'd1, 3'd1); rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(6'd17);
    checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL fullpop_flags got ovf=%0d full=%0d exp ovf=0 full=1", overflow, full); end
    checks++; if (trans_count !== 8'd1) begin errors++; $display("FAIL fullpop_count got %0d exp 1", trans_count); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin errors++; $display("FAIL ovf_pop%0d got %0d exp %0d", k, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %0d exp 1", empty); end
  endtask

  task automatic test_illegal_and_pred();
    drive(3'd1, 3'd6);
    drive(3'd6, 3'd7);
    drive(3'd7, 3'd7);
    checks++; if (illegal !== 1'b1 || illegal_state !== 3'd6) begin errors++; $display("FAIL illegal_capture got flag=%0d state=%0d exp flag=1 state=6", illegal, illegal_state); end
    checks++; if (trans_count !== 8'd3) begin errors++; $display("FAIL illegal_count got %0d exp 3", trans_count); end
    clr = 1'b1; drive(3'd7, 3'd2); clr = 1'b0;
    checks++; if (illegal !== 1'b0 || illegal_state !== 3'd0) begin errors++; $display("FAIL clr_illegal got flag=%0d state=%0d exp 0 0", illegal, illegal_state); end
    checks++; if (trans_count !== 8'd0 || dwell !== 8'd0) begin errors++; $display("FAIL clr_counters got count=%0d dwell=%0d exp 0 0", trans_count, dwell); end
    checks++; if (empty !== 1'b0 || rd_data !== 6'd14) begin errors++; $display("FAIL clr_fifo_intact got empty=%0d data=%0d exp 0 14", empty, rd_data); end
    rd_en = 1'b1;
    drive(3'd2, 3'd3);
    checks++; if (rd_data !== 6'd55 || pred_err !== 1'b0) begin errors++; $display("FAIL pred_before got data=%0d pred=%0d exp 55 0", rd_data, pred_err); end
    drive(3'd2, 3'd2);
    rd_en = 1'b0;
    checks++; if (pred_err !== 1'b1) begin errors++; $display("FAIL pred_set got %0d exp 1", pred_err); end
    checks++; if (rd_data !== 6'd58 || illegal !== 1'b0) begin errors++; $display("FAIL pred_fifo got data=%0d illegal=%0d exp 58 0", rd_data, illegal); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; drive(3'd2, 3'd2); reset = 1'b0;
    checks++; if (pred_err !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL midreset got pred=%0d empty=%0d exp 0 1", pred_err, empty); end
    checks++; if (trans_count !== 8'd0 || dwell !== 8'd0) begin errors++; $display("FAIL midreset_cnt got count=%0d dwell=%0d exp 0 0", trans_count, dwell); end
    rd_en = 1'b1; drive(3'd3, 3'd4); rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || trans_count !== 8'd0) begin errors++; $display("FAIL unprimed got empty=%0d full=%0d count=%0d exp 1 0 0", empty, full, trans_count); end
    checks++; if (pred_err !== 1'b0 || dwell !== 8'd1) begin errors++; $display("FAIL unprimed_flags got pred=%0d dwell=%0d exp 0 1", pred_err, dwell); end
    rd_en = 1'b1; drive(3'd4, 3'd4); rd_en = 1'b0;
    checks++; if (empty !== 1'b0 || rd_data !== 6'd28) begin errors++; $display("FAIL push_pop_empty got empty=%0d data=%0d exp 0 28", empty, rd_data); end
    checks++; if (trans_count !== 8'd1 || pred_err !== 1'b0) begin errors++; $display("FAIL push_pop_empty_cnt got count=%0d pred=%0d exp 1 0", trans_count, pred_err); end
  endtask

  task automatic test_saturate();
    reset = 1'b1; drive(3'd0, 3'd1); reset = 1'b0;
    drive(3'd0, 3'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 260; i++) drive((i % 2 == 0) ? 3'd1 : 3'd0, (i % 2 == 0) ? 3'd0 : 3'd1);
    rd_en = 1'b0;
    checks++; if (trans_count !== 8'd255) begin errors++; $display("FAIL count_sat got %0d exp 255", trans_count); end
    checks++; if (pred_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL sat_flags got pred=%0d ovf=%0d exp 0 0", pred_err, overflow); end
    for (int i = 0; i < 260; i++) drive(3'd0, 3'd0);
    checks++; if (dwell !== 8'd255) begin errors++; $display("FAIL dwell_sat got %0d exp 255", dwell); end
    checks++; if (trans_count !== 8'd255) begin errors++; $display("FAIL count_hold got %0d exp 255", trans_count); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_overflow();
    test_illegal_and_pred();
    test_mid_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
